picomem_spiflash_xip: RTL and testbench
=======================================

PICOMEM_SPIFLASH_XIP -- requirements
Module: picomem_spiflash_xip

Interface
REQ-001 SHALL have parameter CLK_DIV, default 0: SCK half-period equals CLK_DIV+1 clk cycles (HALF), range 0..15.
REQ-002 SHALL have parameter ADDR_BASE_MASK, default 32'h00FF_FFFC: bits of mem_s_addr forwarded to the flash.
REQ-003 SHALL have ports:
 clk  in  1  system clock; sole clock domain.
 resetn  in  1  asynchronous, active-low reset.
 mem_s_valid  in  1  PicoMem request valid; held by master until ready.
 mem_s_ready  out  1  one-cycle acknowledge.
 mem_s_addr  in  32  byte address.
 mem_s_wdata  in  32  write data (ignored).
 mem_s_wstrb  in  4  byte strobes; 0 = read.
 mem_s_rdata  out  32  read data, valid while mem_s_ready=1.
 flash_csb  out  1  SPI chip select, active low.
 flash_clk  out  1  SPI clock, mode 0.
 flash_mosi  out  1  serial data to flash.
 flash_miso  in  1  serial data from flash.

Function
REQ-004 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-005 SHALL start a read only in IDLE, when mem_s_valid=1, mem_s_wstrb=0 and mem_s_ready was 0 in the previous cycle.
REQ-006 SHALL answer a write (wstrb!=0) in the cycle after it is sampled: one-cycle ready pulse, no SPI activity, word-cache invalidated.
REQ-007 SHALL hold a one-entry word cache: tag = mem_s_addr[23:2] plus a valid bit.
REQ-008 SHALL answer a cache-hit read with mem_s_ready one cycle after sampling, with no SPI activity.
REQ-009 SHALL, on a miss, send opcode 8'h03 then 24-bit address {mem_s_addr[23:2],2'b00}, then clock in 32 data bits (64 SCK cycles total).
REQ-010 SHALL shift MOSI MSB first and change it on the SCK falling edge; first bit is valid before the first rising edge.
REQ-011 SHALL sample MISO on the SCK rising edge.
REQ-012 SHALL, on a miss, drive flash_csb low in cycle 1 (cycle 0 = request sampled) and produce the first SCK rising edge HALF cycles later.
REQ-013 SHALL assemble data little-endian: the byte at the word address maps to rdata[7:0] and addr+3 to rdata[31:24].
REQ-014 SHALL assert mem_s_ready exactly 2+128*HALF cycles after the request is sampled.
REQ-015 SHALL raise flash_csb in the DONE cycle and keep it high for at least HALF cycles before the next transaction.
REQ-016 SHALL update the cache tag/data and set valid in the DONE cycle.
REQ-017 SHALL keep mem_s_ready a single-cycle pulse and hold mem_s_rdata stable until the next completion.
REQ-018 SHALL keep flash_clk low whenever flash_csb is high.
REQ-019 SHALL ignore mem_s_valid changes during SHIFT; the address is latched at start.

Reset
REQ-020 SHALL asynchronously force, on resetn=0, even mid-transfer: FSM=IDLE, flash_csb=1, flash_clk=0, flash_mosi=0, mem_s_ready=0, mem_s_rdata=0, cache valid=0, counters=0.
REQ-021 SHALL start no transfer until resetn has been sampled high for one clk edge.

Structure
REQ-022 SHALL place the opcode constant SPI_CMD_READ=8'h03, the FSM state encoding and the bit-count width in shared package picomem_pkg.
REQ-023 SHALL implement SCK generation, the 64-bit shift register and the half-period counter in sub-module picomem_spi_shifter (start/busy/done handshake); the FSM and cache stay in the top module.

Verification
REQ-024 SHALL cover, with CLK_DIV=0 and the flash model holding 0x11223344 little-endian at 0x000100: read 0x00000100 -> ready at cycle 130, rdata=0x11223344, MOSI stream 0x03_000100.
REQ-025 SHALL cover a repeat read of 0x00000100 -> ready at cycle 1, flash_csb stays high.
REQ-026 SHALL cover a write 0xDEADBEEF (wstrb=4'hF) to 0x100, then a read of 0x100 -> write ready at cycle 1, read misses (130 cycles) and returns 0x11223344.
REQ-027 SHALL cover CLK_DIV=3 -> SCK period 8 clk cycles; ready at cycle 514.
REQ-028 SHALL cover resetn pulsed low at cycle 40 of a miss -> flash_csb=1 and flash_clk=0 immediately; the next read of 0x100 misses.
REQ-029 SHALL cover back-to-back misses 0x100 then 0x104 -> flash_csb high for at least HALF cycles between them; each rdata is correct.

Source files
------------

// File: rtl/picomem_pkg.sv
// rtl/picomem_pkg.sv - shared constants, FSM encoding and helpers for the SPI-flash XIP bridge
// Contents:
//   SPI_CMD_READ  plain read opcode sent ahead of every miss
//   BIT_CNT_W     width of the SCK-cycle counter (64 cycles per transfer)
//   xip_state_t   IDLE / SHIFT / DONE encoding of the bridge FSM
//   bswap32       reorders a serially received word into little-endian bus order
package picomem_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         BIT_CNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } xip_state_t;

    // The first byte clocked out of the flash is the lowest-addressed byte,
    // so it lands in the top of the shift register and belongs in [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/picomem_spi_shifter.sv
// rtl/picomem_spi_shifter.sv - mode-0 SPI engine: SCK divider and 64-bit shift register
// Ports:
//   clk, resetn   system clock, asynchronous active-low reset
//   start         load tx_data and begin a 64-SCK-cycle transfer (ignored while busy)
//   tx_data       64 bits sent MSB first
//   miso          serial input, sampled on SCK rising edges
//   sck, mosi     SPI clock (idle low) and serial output (changes on SCK falling edges)
//   busy          transfer in progress
//   done          one-cycle pulse after the last SCK falling edge
//   rx_data       last 32 bits received, first received bit in [31]
module picomem_spi_shifter
    import picomem_pkg::*;
#(
    parameter int CLK_DIV = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] tx_data,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data
);

    localparam logic [3:0] HALF_LAST = 4'(CLK_DIV);

    logic [3:0]           half_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [63:0]          shreg;

    // One register serves both directions: each rising edge shifts the
    // transmitted MSB out and the sampled MISO bit in at the bottom, so after
    // 64 cycles the low half holds the 32 data bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    shreg    <= tx_data;
                    mosi     <= tx_data[63];
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    sck      <= 1'b0;
                end
            end else if (half_cnt != HALF_LAST) begin
                half_cnt <= half_cnt + 4'd1;
            end else begin
                half_cnt <= '0;
                if (!sck) begin
                    sck   <= 1'b1;
                    shreg <= {shreg[62:0], miso};
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == '1) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        mosi <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        mosi    <= shreg[63];
                    end
                end
            end
        end
    end

    assign rx_data = shreg[31:0];

endmodule

// File: rtl/picomem_spiflash_xip.sv
// rtl/picomem_spiflash_xip.sv - PicoMem slave serving reads from SPI flash with a one-word cache
// Ports:
//   clk, resetn                 system clock, asynchronous active-low reset
//   mem_s_valid/ready           request held by master / one-cycle acknowledge
//   mem_s_addr, mem_s_wdata     byte address, write data (writes are acknowledged and dropped)
//   mem_s_wstrb                 byte strobes, zero means read
//   mem_s_rdata                 read data, held until the next completion
//   flash_csb/clk/mosi/miso     SPI mode-0 flash pins
module picomem_spiflash_xip
    import picomem_pkg::*;
#(
    parameter int          CLK_DIV        = 0,
    parameter logic [31:0] ADDR_BASE_MASK = 32'h00FF_FFFC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_s_valid,
    output logic        mem_s_ready,
    input  logic [31:0] mem_s_addr,
    input  logic [31:0] mem_s_wdata,
    input  logic [3:0]  mem_s_wstrb,
    output logic [31:0] mem_s_rdata,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    xip_state_t  state_q, state_d;

    logic        armed;
    logic        cache_valid;
    logic [21:0] cache_tag;
    logic [31:0] cache_data;
    logic [21:0] pend_tag;
    logic [3:0]  gap_cnt;

    logic        req_ok, is_write, hit;
    logic        wr_ack, hit_ack, start_xfer, fill;

    logic [21:0] word_addr;
    logic [63:0] spi_tx;
    logic [31:0] spi_rx;
    logic        spi_busy, spi_done;

    logic        unused_bits;
    assign unused_bits = ^{mem_s_wdata, mem_s_addr[31:24], mem_s_addr[1:0]};

    assign word_addr = mem_s_addr[23:2] & ADDR_BASE_MASK[23:2];
    assign spi_tx    = {SPI_CMD_READ, word_addr, 2'b00, 32'h0000_0000};

    picomem_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start_xfer),
        .tx_data (spi_tx),
        .miso    (flash_miso),
        .sck     (flash_clk),
        .mosi    (flash_mosi),
        .busy    (spi_busy),
        .done    (spi_done),
        .rx_data (spi_rx)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_xfer) state_d = SHIFT;
            SHIFT:   if (spi_done)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. A request is accepted only when the previous cycle did
    // not acknowledge, so a master still holding valid after ready is not
    // served twice. Misses additionally wait for the chip-select gap to expire.
    always_comb begin
        req_ok     = armed && mem_s_valid && !mem_s_ready;
        is_write   = (mem_s_wstrb != 4'b0000);
        hit        = cache_valid && (cache_tag == mem_s_addr[23:2]);
        wr_ack     = 1'b0;
        hit_ack    = 1'b0;
        start_xfer = 1'b0;
        fill       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (is_write) begin
                        wr_ack = 1'b1;
                    end else if (hit) begin
                        hit_ack = 1'b1;
                    end else if (gap_cnt == 4'd0 && !spi_busy) begin
                        start_xfer = 1'b1;
                    end
                end
            end
            SHIFT:   fill = spi_done;
            default: ;
        endcase
    end

    // Bus response, cache and chip select. The fill happens on the edge that
    // enters DONE, so ready, fresh data and a raised chip select are all
    // visible during the DONE cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed       <= 1'b0;
            mem_s_ready <= 1'b0;
            mem_s_rdata <= '0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
            pend_tag    <= '0;
            gap_cnt     <= '0;
            flash_csb   <= 1'b1;
        end else begin
            armed       <= 1'b1;
            mem_s_ready <= wr_ack | hit_ack | fill;

            if (hit_ack) begin
                mem_s_rdata <= cache_data;
            end

            if (wr_ack) begin
                cache_valid <= 1'b0;
            end

            if (start_xfer) begin
                flash_csb <= 1'b0;
                pend_tag  <= mem_s_addr[23:2];
            end

            // gap_cnt keeps chip select high for a full SCK half-period
            // (DONE cycle plus CLK_DIV idle cycles) before the next miss.
            if (fill) begin
                flash_csb   <= 1'b1;
                mem_s_rdata <= bswap32(spi_rx);
                cache_data  <= bswap32(spi_rx);
                cache_tag   <= pend_tag;
                cache_valid <= 1'b1;
                gap_cnt     <= 4'(CLK_DIV);
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_picomem_spiflash_xip.sv
// tb/tb_picomem_spiflash_xip.sv - directed self-checking bench for picomem_spiflash_xip
module tb_picomem_spiflash_xip;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [3:0]  ws0 = '0, ws1 = '0;
    logic        rdy0, rdy1;
    logic [31:0] rd0, rd1;
    logic        csb0, csb1, sck0, sck1, mosi0, mosi1;
    logic        miso = 1'b0;
    logic        sel = 1'b0;

    logic        m_csb, m_clk, m_mosi;
    assign m_csb  = sel ? csb1  : csb0;
    assign m_clk  = sel ? sck1  : sck0;
    assign m_mosi = sel ? mosi1 : mosi0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    picomem_spiflash_xip #(.CLK_DIV(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .mem_s_valid(v0), .mem_s_ready(rdy0), .mem_s_addr(a0),
        .mem_s_wdata(wd0), .mem_s_wstrb(ws0), .mem_s_rdata(rd0),
        .flash_csb(csb0), .flash_clk(sck0), .flash_mosi(mosi0), .flash_miso(miso)
    );

    picomem_spiflash_xip #(.CLK_DIV(3)) dut1 (
        .clk(clk), .resetn(resetn),
        .mem_s_valid(v1), .mem_s_ready(rdy1), .mem_s_addr(a1),
        .mem_s_wdata(wd1), .mem_s_wstrb(ws1), .mem_s_rdata(rd1),
        .flash_csb(csb1), .flash_clk(sck1), .flash_mosi(mosi1), .flash_miso(miso)
    );

    // Flash model: 0x100 holds 0x11223344, 0x104 holds 0x55667788 (little-endian)
    logic [7:0]  fl_mem [0:511];
    int          fl_bits;
    logic [31:0] fl_cmd;
    int          fl_idx;
    logic [23:0] fl_ba;
    logic [2:0]  fl_bit;

    always @(negedge m_csb or posedge m_clk) begin
        if (!m_clk) begin
            fl_bits = 0;
            fl_cmd  = '0;
        end else if (!m_csb) begin
            if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], m_mosi};
            fl_bits++;
        end
    end

    always @(negedge m_clk) begin
        if (!m_csb && fl_bits >= 32) begin
            fl_idx = fl_bits - 32;
            fl_ba  = fl_cmd[23:0] + 24'(fl_idx / 8);
            fl_bit = 3'(7 - (fl_idx % 8));
            miso   = fl_mem[fl_ba[8:0]][fl_bit];
        end
    end

    // Monitors: SCK must be low while deselected; length of each CS-high run
    int sck_viol = 0;
    int hi_run = 0;
    int last_gap = 0;
    always @(negedge clk) begin
        if ((csb0 === 1'b1 && sck0 !== 1'b0) || (csb1 === 1'b1 && sck1 !== 1'b0)) sck_viol++;
        if (m_csb === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_req(input bit s, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output int cyc, output logic [31:0] data,
                          output bit csb_low, output logic csb_c1, output int rise_cyc);
        bit got;
        got = 1'b0; cyc = 0; data = '0; csb_low = 1'b0; csb_c1 = 1'bx; rise_cyc = 0;
        sel = s;
        if (!s) begin a0 = addr; wd0 = wdata; ws0 = wstrb; v0 = 1'b1; end
        else    begin a1 = addr; wd1 = wdata; ws1 = wstrb; v1 = 1'b1; end
        while (!got && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) csb_c1 = m_csb;
            if (m_csb === 1'b0) csb_low = 1'b1;
            if (m_clk === 1'b1 && rise_cyc == 0) rise_cyc = cyc;
            if ((s ? rdy1 : rdy0) === 1'b1) begin
                got = 1'b1;
                data = s ? rd1 : rd0;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL req_timeout: addr %h ready never seen in %0d cycles, want ready", addr, cyc);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy0); end
        n_cmp++; if (rd0 !== 32'h0)   begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rd0); end
        n_cmp++; if (csb0 !== 1'b1)   begin n_fail++; $display("FAIL reset_csb: got %b want 1", csb0); end
        n_cmp++; if (sck0 !== 1'b0)   begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck0); end
        n_cmp++; if (mosi0 !== 1'b0)  begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
        resetn = 1'b1;
        idle(4);
    endtask

    task automatic test_miss();
        int cyc, rise; logic [31:0] d; bit lo; logic c1;
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (cyc != 130)          begin n_fail++; $display("FAIL miss_latency: got %0d want 130", cyc); end
        n_cmp++; if (d !== 32'h11223344)  begin n_fail++; $display("FAIL miss_rdata: got %h want 11223344", d); end
        n_cmp++; if (c1 !== 1'b0)         begin n_fail++; $display("FAIL miss_csb_cycle1: got %b want 0", c1); end
        n_cmp++; if (rise != 2)           begin n_fail++; $display("FAIL miss_first_rise: got %0d want 2", rise); end
        n_cmp++; if (fl_cmd !== 32'h03000100) begin n_fail++; $display("FAIL miss_mosi: got %h want 03000100", fl_cmd); end
        idle(3);
    endtask

    task automatic test_hit();
        int cyc, rise; logic [31:0] d; bit lo; logic c1;
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (cyc != 1)            begin n_fail++; $display("FAIL hit_latency: got %0d want 1", cyc); end
        n_cmp++; if (d !== 32'h11223344)  begin n_fail++; $display("FAIL hit_rdata: got %h want 11223344", d); end
        n_cmp++; if (lo !== 1'b0)         begin n_fail++; $display("FAIL hit_csb_low: got %b want 0", lo); end
        idle(3);
        n_cmp++; if (rd0 !== 32'h11223344) begin n_fail++; $display("FAIL hit_rdata_hold: got %h want 11223344", rd0); end
        n_cmp++; if (rdy0 !== 1'b0)       begin n_fail++; $display("FAIL hit_ready_pulse: got %b want 0", rdy0); end
    endtask

    task automatic test_write();
        int cyc, rise; logic [31:0] d; bit lo; logic c1;
        do_req(1'b0, 32'h0000_0100, 32'hDEADBEEF, 4'hF, cyc, d, lo, c1, rise);
        n_cmp++; if (cyc != 1)            begin n_fail++; $display("FAIL write_latency: got %0d want 1", cyc); end
        n_cmp++; if (lo !== 1'b0)         begin n_fail++; $display("FAIL write_csb_low: got %b want 0", lo); end
        idle(3);
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (cyc != 130)          begin n_fail++; $display("FAIL write_reread_latency: got %0d want 130", cyc); end
        n_cmp++; if (d !== 32'h11223344)  begin n_fail++; $display("FAIL write_reread_rdata: got %h want 11223344", d); end
        idle(3);
    endtask

    task automatic test_clk_div();
        int cyc, rise; logic [31:0] d; bit lo; logic c1;
        do_req(1'b1, 32'h0000_0100, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (cyc != 514)          begin n_fail++; $display("FAIL div3_latency: got %0d want 514", cyc); end
        n_cmp++; if (d !== 32'h11223344)  begin n_fail++; $display("FAIL div3_rdata: got %h want 11223344", d); end
        n_cmp++; if (rise != 5)           begin n_fail++; $display("FAIL div3_first_rise: got %0d want 5", rise); end
        n_cmp++; if (fl_cmd !== 32'h03000100) begin n_fail++; $display("FAIL div3_mosi: got %h want 03000100", fl_cmd); end
        idle(3);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc, rise; logic [31:0] d; bit lo; logic c1;
        logic pre_csb;
        sel = 1'b0;
        a0 = 32'h0000_0104; ws0 = 4'h0; v0 = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        pre_csb = csb0;
        resetn = 1'b0;
        #1;
        n_cmp++; if (pre_csb !== 1'b0)    begin n_fail++; $display("FAIL rstmid_active: got csb %b want 0", pre_csb); end
        n_cmp++; if (csb0 !== 1'b1)       begin n_fail++; $display("FAIL rstmid_csb: got %b want 1", csb0); end
        n_cmp++; if (sck0 !== 1'b0)       begin n_fail++; $display("FAIL rstmid_sck: got %b want 0", sck0); end
        v0 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(4);
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (cyc != 130)          begin n_fail++; $display("FAIL rstmid_reread_latency: got %0d want 130", cyc); end
        n_cmp++; if (d !== 32'h11223344)  begin n_fail++; $display("FAIL rstmid_reread_rdata: got %h want 11223344", d); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        int cyc, rise; logic [31:0] d; bit lo; logic c1;
        do_req(1'b1, 32'h0000_0100, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (d !== 32'h11223344)  begin n_fail++; $display("FAIL b2b_first_rdata: got %h want 11223344", d); end
        do_req(1'b1, 32'h0000_0104, 32'h0, 4'h0, cyc, d, lo, c1, rise);
        n_cmp++; if (d !== 32'h55667788)  begin n_fail++; $display("FAIL b2b_second_rdata: got %h want 55667788", d); end
        n_cmp++; if (last_gap < 4)        begin n_fail++; $display("FAIL b2b_csb_gap: got %0d cycles want >= 4", last_gap); end
        idle(3);
        sel = 1'b0;
    endtask

    task automatic test_sck_idle();
        n_cmp++; if (sck_viol != 0)       begin n_fail++; $display("FAIL sck_while_deselected: got %0d cycles want 0", sck_viol); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) fl_mem[i] = 8'h00;
        fl_mem[256] = 8'h44; fl_mem[257] = 8'h33; fl_mem[258] = 8'h22; fl_mem[259] = 8'h11;
        fl_mem[260] = 8'h88; fl_mem[261] = 8'h77; fl_mem[262] = 8'h66; fl_mem[263] = 8'h55;

        test_reset();
        test_miss();
        test_hit();
        test_write();
        test_clk_div();
        test_reset_mid();
        test_back_to_back();
        test_sck_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
